// File: rtl/fwd_pkg.sv
// Shared definitions for the EX-stage forwarding and hazard unit:
// scoreboard states, select encodings and the select-width helper.
package fwd_pkg;

  typedef enum logic [1:0] {
    MC_IDLE = 2'd0,
    MC_BUSY = 2'd1,
    MC_WB   = 2'd2
  } mc_state_e;

  localparam int FWD_SEL_RF = 0;

  // The multi-cycle result sits one code above the oldest pipeline stage.
  function automatic int fwd_sel_mc(input int nstage);
    return nstage + 1;
  endfunction

  function automatic int sel_w(input int nstage);
    return $clog2(nstage + 2);
  endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// Operand, write-stage, multi-cycle and result signals of fwd_hazard_unit.
// Inputs are pure levels sampled every cycle; no valid/ready handshake here.
interface fwd_hazard_unit_if #(
  parameter int NSRC   = 2,
  parameter int NSTAGE = 2,
  parameter int AW     = 5,
  parameter int LAT_W  = 6
);
  localparam int SELW = fwd_pkg::sel_w(NSTAGE);

  logic [NSRC*AW-1:0]   src_addr_ex;
  logic [NSRC-1:0]      src_used_ex;
  logic [NSTAGE-1:0]    wr_en_stg;
  logic [NSTAGE*AW-1:0] wr_addr_stg;
  logic [NSTAGE-1:0]    wr_ready_stg;
  logic                 mc_issue;
  logic [AW-1:0]        mc_rd;
  logic [LAT_W-1:0]     mc_lat;
  logic                 mc_kill;
  logic [NSRC*SELW-1:0] fwd_sel;
  logic                 stall_ex;
  logic                 mc_ready;
  logic                 mc_wb_valid;
  logic [1:0]           mc_state;

  modport master (
    output src_addr_ex, src_used_ex, wr_en_stg, wr_addr_stg, wr_ready_stg,
    output mc_issue, mc_rd, mc_lat, mc_kill,
    input  fwd_sel, stall_ex, mc_ready, mc_wb_valid, mc_state
  );

  modport slave (
    input  src_addr_ex, src_used_ex, wr_en_stg, wr_addr_stg, wr_ready_stg,
    input  mc_issue, mc_rd, mc_lat, mc_kill,
    output fwd_sel, stall_ex, mc_ready, mc_wb_valid, mc_state
  );

endinterface

// File: rtl/fwd_match.sv
// Priority match of one source operand against the downstream write stages;
// the youngest (lowest index) matching stage wins.
module fwd_match #(
  parameter int NSTAGE = 2,
  parameter int AW     = 5,
  parameter int SELW   = 2
) (
  input  logic [AW-1:0]        src_addr,
  input  logic [NSTAGE-1:0]    wr_en,
  input  logic [NSTAGE*AW-1:0] wr_addr,
  input  logic [NSTAGE-1:0]    wr_ready,
  output logic [SELW-1:0]      sel,
  output logic                 hit,
  output logic                 not_ready
);

  // Walking from oldest to youngest lets the youngest match overwrite.
  always_comb begin
    sel       = '0;
    hit       = 1'b0;
    not_ready = 1'b0;
    for (int k = NSTAGE - 1; k >= 0; k--) begin
      if (wr_en[k] && (wr_addr[k*AW +: AW] != '0) &&
          (wr_addr[k*AW +: AW] == src_addr)) begin
        sel       = SELW'(k + 1);
        hit       = 1'b1;
        not_ready = !wr_ready[k];
      end
    end
  end

endmodule

// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding, load-use stall and multi-cycle scoreboard.
// Optional build macro FWD_STALL_CNT_EN adds a saturating stall_cnt output.
module fwd_hazard_unit
  import fwd_pkg::*;
#(
  parameter int NSRC   = 2,
  parameter int NSTAGE = 2,
  parameter int AW     = 5,
  parameter int LAT_W  = 6
) (
  input  logic              clk,
  input  logic              rst,
  fwd_hazard_unit_if.slave  bus
`ifdef FWD_STALL_CNT_EN
  ,
  output logic [31:0]       stall_cnt
`endif
);

  localparam int              SELW   = sel_w(NSTAGE);
  localparam logic [SELW-1:0] SEL_RF = SELW'(FWD_SEL_RF);
  localparam logic [SELW-1:0] SEL_MC = SELW'(fwd_sel_mc(NSTAGE));
  localparam logic [1:0]      S_IDLE = MC_IDLE;
  localparam logic [1:0]      S_BUSY = MC_BUSY;
  localparam logic [1:0]      S_WB   = MC_WB;

  logic [1:0]       state_q, state_d;
  logic [LAT_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]    mc_rd_q, mc_rd_d;

  logic [NSRC*SELW-1:0] stage_sel;
  logic [NSRC-1:0]      stage_hit;
  logic [NSRC-1:0]      stage_nr;
  logic [NSRC-1:0]      op_mc_hit;
  logic [NSRC-1:0]      op_stall;
  logic [NSRC*SELW-1:0] fwd_sel_c;
  logic                 stall_c;

  for (genvar i = 0; i < NSRC; i++) begin : g_op
    fwd_match #(
      .NSTAGE (NSTAGE),
      .AW     (AW),
      .SELW   (SELW)
    ) u_match (
      .src_addr  (bus.src_addr_ex[i*AW +: AW]),
      .wr_en     (bus.wr_en_stg),
      .wr_addr   (bus.wr_addr_stg),
      .wr_ready  (bus.wr_ready_stg),
      .sel       (stage_sel[i*SELW +: SELW]),
      .hit       (stage_hit[i]),
      .not_ready (stage_nr[i])
    );

    // x0 is never a real dependency, even if the divider targets it.
    assign op_mc_hit[i] = bus.src_used_ex[i] && (mc_rd_q != '0) &&
                          (bus.src_addr_ex[i*AW +: AW] == mc_rd_q);

    assign op_stall[i] = (bus.src_used_ex[i] && stage_hit[i] && stage_nr[i]) ||
                         (op_mc_hit[i] && (state_q == S_BUSY));

    // Pipeline stages are younger than the multi-cycle result, so they win.
    assign fwd_sel_c[i*SELW +: SELW] =
      stage_hit[i]                         ? stage_sel[i*SELW +: SELW] :
      (op_mc_hit[i] && (state_q == S_WB))  ? SEL_MC : SEL_RF;
  end

  assign stall_c         = |op_stall;
  assign bus.fwd_sel     = fwd_sel_c;
  assign bus.stall_ex    = stall_c;
  assign bus.mc_ready    = (state_q == S_IDLE) || (state_q == S_WB);
  assign bus.mc_wb_valid = (state_q == S_WB);
  assign bus.mc_state    = state_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mc_rd_d = mc_rd_q;
    case (state_q)
      S_IDLE, S_WB: begin
        if (bus.mc_issue) begin
          state_d = S_BUSY;
          mc_rd_d = bus.mc_rd;
          cnt_d   = (bus.mc_lat == '0) ? LAT_W'(1) : bus.mc_lat;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        if (cnt_q != '0) cnt_d = cnt_q - LAT_W'(1);
        if (cnt_q <= LAT_W'(1)) state_d = S_WB;
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
    // A flush overrides everything, including a same-cycle issue.
    if (bus.mc_kill) begin
      state_d = S_IDLE;
      cnt_d   = '0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      mc_rd_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      mc_rd_q <= mc_rd_d;
    end
  end

`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt_q, stall_cnt_d;

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (stall_c && (stall_cnt_q != 32'hFFFF_FFFF)) stall_cnt_d = stall_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) stall_cnt_q <= '0;
    else     stall_cnt_q <= stall_cnt_d;
  end

  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Self-checking bench for fwd_hazard_unit: per-cycle expected outputs are
// queued as stimulus is driven and compared at the following falling edge.
module tb_fwd_hazard_unit;
  localparam int NSRC   = 2;
  localparam int NSTAGE = 2;
  localparam int AW     = 5;
  localparam int LAT_W  = 6;
  localparam int SELW   = 2;
  localparam int EW     = NSRC * SELW + 3;

  logic clk;
  logic rst;
  int   checks;
  int   errors;
  logic [EW-1:0] exp_q[$];
  logic [EW-1:0] obs;
  logic [EW-1:0] want;
`ifdef FWD_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  fwd_hazard_unit_if #(.NSRC(NSRC), .NSTAGE(NSTAGE), .AW(AW), .LAT_W(LAT_W)) bus ();

  fwd_hazard_unit #(.NSRC(NSRC), .NSTAGE(NSTAGE), .AW(AW), .LAT_W(LAT_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
`ifdef FWD_STALL_CNT_EN
    ,
    .stall_cnt (stall_cnt)
`endif
  );

  assign obs = {bus.fwd_sel, bus.stall_ex, bus.mc_ready, bus.mc_wb_valid};

  // ---------------- clock ----------------
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [EW-1:0] pack(input logic [SELW-1:0] s1, input logic [SELW-1:0] s0,
                                         input logic st, input logic rdy, input logic wbv);
    return {s1, s0, st, rdy, wbv};
  endfunction

  // ---------------- driver tasks ----------------
  task automatic set_idle();
    bus.src_addr_ex  = '0;
    bus.src_used_ex  = '0;
    bus.wr_en_stg    = '0;
    bus.wr_addr_stg  = '0;
    bus.wr_ready_stg = '0;
    bus.mc_issue     = 1'b0;
    bus.mc_rd        = '0;
    bus.mc_lat       = '0;
    bus.mc_kill      = 1'b0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_ops(input logic [AW-1:0] a1, input logic [AW-1:0] a0, input logic [1:0] used);
    bus.src_addr_ex = {a1, a0};
    bus.src_used_ex = used;
  endtask

  task automatic drive_issue(input logic iss, input logic [AW-1:0] rd, input logic [LAT_W-1:0] lat);
    bus.mc_issue = iss;
    bus.mc_rd    = rd;
    bus.mc_lat   = lat;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    exp_q.push_back(pack(0, 0, 0, 1, 0));
    @(negedge clk);
    want = exp_q.pop_front();
    checks++;
    if (obs !== want) begin
      errors++;
      $display("FAIL reset outputs: got %b expected %b", obs, want);
    end
`ifdef FWD_STALL_CNT_EN
    checks++;
    if (stall_cnt !== 32'd0) begin
      errors++;
      $display("FAIL reset stall_cnt: got %0d expected 0", stall_cnt);
    end
`endif
    next_cycle();
    rst = 1'b0;
    next_cycle();
  endtask

  task automatic test_forwarding();
    for (int c = 0; c < 6; c++) begin
      set_idle();
      case (c)
        0: begin
          drive_ops(5'd0, 5'd5, 2'b01);
          bus.wr_en_stg = 2'b11; bus.wr_addr_stg = {5'd5, 5'd5}; bus.wr_ready_stg = 2'b11;
          exp_q.push_back(pack(0, 1, 0, 1, 0));
        end
        1: begin
          drive_ops(5'd0, 5'd5, 2'b01);
          bus.wr_en_stg = 2'b11; bus.wr_addr_stg = {5'd5, 5'd3}; bus.wr_ready_stg = 2'b11;
          exp_q.push_back(pack(0, 2, 0, 1, 0));
        end
        2: begin
          drive_ops(5'd7, 5'd0, 2'b10);
          bus.wr_en_stg = 2'b01; bus.wr_addr_stg = {5'd0, 5'd7}; bus.wr_ready_stg = 2'b00;
          exp_q.push_back(pack(1, 0, 1, 1, 0));
        end
        3: begin
          drive_ops(5'd7, 5'd0, 2'b00);
          bus.wr_en_stg = 2'b01; bus.wr_addr_stg = {5'd0, 5'd7}; bus.wr_ready_stg = 2'b00;
          exp_q.push_back(pack(1, 0, 0, 1, 0));
        end
        4: begin
          drive_ops(5'd0, 5'd0, 2'b11);
          bus.wr_en_stg = 2'b11; bus.wr_addr_stg = {5'd0, 5'd0}; bus.wr_ready_stg = 2'b00;
          exp_q.push_back(pack(0, 0, 0, 1, 0));
        end
        default: begin
          drive_ops(5'd5, 5'd5, 2'b11);
          bus.wr_en_stg = 2'b00; bus.wr_addr_stg = {5'd5, 5'd5}; bus.wr_ready_stg = 2'b00;
          exp_q.push_back(pack(0, 0, 0, 1, 0));
        end
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL forwarding case %0d: got %b expected %b", c, obs, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_random_forwarding();
    logic [NSRC*SELW-1:0] sel_m;
    logic                 stall_m;
    logic                 found;
    logic [AW-1:0]        src;
    for (int n = 0; n < 30; n++) begin
      set_idle();
      drive_ops(AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      bus.wr_en_stg    = 2'($urandom_range(0, 3));
      bus.wr_addr_stg  = {AW'($urandom_range(0, 3)), AW'($urandom_range(0, 3))};
      bus.wr_ready_stg = 2'($urandom_range(0, 3));
      sel_m   = '0;
      stall_m = 1'b0;
      for (int i = 0; i < NSRC; i++) begin
        src   = bus.src_addr_ex[i*AW +: AW];
        found = 1'b0;
        for (int k = 0; k < NSTAGE; k++) begin
          if (!found && bus.wr_en_stg[k] && src != 0 && bus.wr_addr_stg[k*AW +: AW] == src) begin
            found = 1'b1;
            sel_m[i*SELW +: SELW] = SELW'(k + 1);
            if (!bus.wr_ready_stg[k] && bus.src_used_ex[i]) stall_m = 1'b1;
          end
        end
      end
      exp_q.push_back({sel_m, stall_m, 1'b1, 1'b0});
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL random forwarding %0d: got %b expected %b", n, obs, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_mc_basic(input logic [LAT_W-1:0] lat);
    int eff;
`ifdef FWD_STALL_CNT_EN
    logic [31:0] cnt0;
    cnt0 = stall_cnt;
`endif
    eff = (lat == 0) ? 1 : int'(lat);
    for (int c = 0; c <= eff + 2; c++) begin
      set_idle();
      drive_ops(5'd0, 5'd9, 2'b01);
      drive_issue(c == 0, 5'd9, lat);
      if (c == 0)            exp_q.push_back(pack(0, 0, 0, 1, 0));
      else if (c <= eff)     exp_q.push_back(pack(0, 0, 1, 0, 0));
      else if (c == eff + 1) exp_q.push_back(pack(0, 3, 0, 1, 1));
      else                   exp_q.push_back(pack(0, 0, 0, 1, 0));
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL mc basic lat %0d cycle %0d: got %b expected %b", lat, c, obs, want);
      end
      next_cycle();
    end
`ifdef FWD_STALL_CNT_EN
    checks++;
    if (stall_cnt - cnt0 !== 32'(eff)) begin
      errors++;
      $display("FAIL mc basic stall_cnt delta: got %0d expected %0d", stall_cnt - cnt0, eff);
    end
`endif
  endtask

  task automatic test_back_to_back();
    for (int c = 0; c < 9; c++) begin
      set_idle();
      drive_ops(5'd12, 5'd9, 2'b11);
      case (c)
        0:       begin drive_issue(1, 5'd9, 6'd3);  exp_q.push_back(pack(0, 0, 0, 1, 0)); end
        1, 2, 3: begin drive_issue(1, 5'd12, 6'd2); exp_q.push_back(pack(0, 0, 1, 0, 0)); end
        4:       begin drive_issue(1, 5'd12, 6'd2); exp_q.push_back(pack(0, 3, 0, 1, 1)); end
        5, 6:    exp_q.push_back(pack(0, 0, 1, 0, 0));
        7: begin
          bus.wr_en_stg = 2'b10; bus.wr_addr_stg = {5'd12, 5'd0}; bus.wr_ready_stg = 2'b10;
          exp_q.push_back(pack(2, 0, 0, 1, 1));
        end
        default: exp_q.push_back(pack(0, 0, 0, 1, 0));
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL back to back cycle %0d: got %b expected %b", c, obs, want);
      end
      next_cycle();
    end
  endtask

  task automatic test_abort(input logic use_rst);
`ifdef FWD_STALL_CNT_EN
    logic [31:0] cnt0;
    cnt0 = stall_cnt;
`endif
    for (int c = 0; c < 7; c++) begin
      set_idle();
      rst = 1'b0;
      drive_ops(5'd0, 5'd9, 2'b01);
      case (c)
        0: begin drive_issue(1, 5'd9, 6'd4); exp_q.push_back(pack(0, 0, 0, 1, 0)); end
        1: exp_q.push_back(pack(0, 0, 1, 0, 0));
        2: begin
          drive_issue(1, 5'd9, 6'd2);
          if (use_rst) begin
            rst = 1'b1;
            exp_q.push_back(pack(0, 0, 0, 1, 0));
          end else begin
            bus.mc_kill = 1'b1;
            exp_q.push_back(pack(0, 0, 1, 0, 0));
          end
        end
        default: exp_q.push_back(pack(0, 0, 0, 1, 0));
      endcase
      @(negedge clk);
      want = exp_q.pop_front();
      checks++;
      if (obs !== want) begin
        errors++;
        $display("FAIL abort rst=%0d cycle %0d: got %b expected %b", use_rst, c, obs, want);
      end
      next_cycle();
    end
    rst = 1'b0;
`ifdef FWD_STALL_CNT_EN
    checks++;
    if (use_rst ? (stall_cnt !== 32'd0) : (stall_cnt - cnt0 !== 32'd2)) begin
      errors++;
      $display("FAIL abort rst=%0d stall_cnt: got %0d start %0d", use_rst, stall_cnt, cnt0);
    end
`endif
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    checks = 0;
    errors = 0;
    test_reset();
    test_forwarding();
    test_random_forwarding();
    test_mc_basic(6'd3);
    test_mc_basic(6'd0);
    test_mc_basic(6'd5);
    test_back_to_back();
    test_abort(1'b0);
    test_abort(1'b1);
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard leftover: got %0d entries expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
